// File: rtl/axi_wr_burst_slv_pkg.sv
// Shared encodings for the AXI write-burst slave: burst types, response codes, FSM states.
// The WRAP burst decode helper is only used when AXI_WR_WRAP_EN is defined.
package axi_wr_burst_slv_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_e;

  // WRAP bursts must be 2, 4, 8 or 16 beats long.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_wr_burst_slv_aw_fifo.sv
// Outstanding write-address queue. The ready output is registered and reflects
// "not full" after the current cycle's push/pop has been applied.
module axi_aw_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  output logic         ready_o,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic          ready_q;
  logic          do_push, do_pop;

  assign do_push = push_i & ready_q;
  assign do_pop  = pop_i & (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d != FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign ready_o = ready_q;

endmodule

// File: rtl/axi_wr_burst_slv.sv
// AXI4 write-burst slave: queues AW requests, walks each burst's beats onto a
// registered sink interface and returns B responses in AW order. WRAP bursts need AXI_WR_WRAP_EN.
module axi_wr_burst_slv
  import axi_wr_burst_slv_pkg::*;
#(
  parameter int ID_W     = 8,
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int AW_DEPTH = 4,
  parameter int STRB_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   awid_i,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic [7:0]        awlen_i,
  input  logic [2:0]        awsize_i,
  input  logic [1:0]        awburst_i,
  input  logic [3:0]        awregion_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic              wlast_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [ID_W-1:0]   bid_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  output logic              wr_vld_o,
  input  logic              wr_rdy_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic [STRB_W-1:0] wr_strb_o,
  output logic [3:0]        wr_region_o,
  output logic              wr_last_o,
  input  logic              wr_err_i
);

  // All channels use valid/ready: a transfer happens on a rising edge where both are high;
  // once valid is raised its payload stays stable until the transfer.

  localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_W));
  localparam int         ENT_W    = ID_W + ADDR_W + 8 + 3 + 2 + 4 + 1;

  logic [ENT_W-1:0]  aw_din, aw_dout;
  logic              aw_empty, aw_pop, aw_err;
  logic [ID_W-1:0]   ent_id;
  logic [ADDR_W-1:0] ent_addr;
  logic [7:0]        ent_len;
  logic [2:0]        ent_size;
  logic [1:0]        ent_burst;
  logic [3:0]        ent_region;
  logic              ent_err;

  wr_state_e         state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_nx, incr;
  logic [7:0]        rem_q, rem_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        mode_q, mode_d;
  logic [3:0]        region_q, region_d;
  logic              err_q, err_d;
  logic              supp_q, supp_d;
  logic              bvalid_q, bvalid_d;
  logic              out_vld_q, out_vld_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [STRB_W-1:0] out_strb_q, out_strb_d;
  logic [3:0]        out_region_q, out_region_d;
  logic              out_last_q, out_last_d;
  logic              w_acc, w_final, sink_acc;

`ifdef AXI_WR_WRAP_EN
  logic [7:0]        len_q, len_d;
  logic [ADDR_W-1:0] size_mask, wrap_mask;
  assign size_mask = (ADDR_W'(1) << awsize_i) - 1'b1;
  assign wrap_mask = (ADDR_W'(len_q) << size_q) | (incr - 1'b1);
`endif

  // Errors detectable from the AW beat alone are resolved before the entry is queued.
  always_comb begin
    aw_err = 1'b0;
    if (awsize_i > SIZE_MAX) aw_err = 1'b1;
    if (awburst_i == BURST_RSVD) aw_err = 1'b1;
`ifdef AXI_WR_WRAP_EN
    if ((awburst_i == BURST_WRAP) &&
        (!wrap_len_ok(awlen_i) || ((awaddr_i & size_mask) != '0))) aw_err = 1'b1;
`else
    if (awburst_i == BURST_WRAP) aw_err = 1'b1;
`endif
  end

  assign aw_din = {awid_i, awaddr_i, awlen_i, awsize_i, awburst_i, awregion_i, aw_err};
  assign {ent_id, ent_addr, ent_len, ent_size, ent_burst, ent_region, ent_err} = aw_dout;

  axi_aw_fifo #(
    .W     (ENT_W),
    .DEPTH (AW_DEPTH)
  ) u_aw_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (awvalid_i),
    .din_i   (aw_din),
    .ready_o (awready_o),
    .pop_i   (aw_pop),
    .dout_o  (aw_dout),
    .empty_o (aw_empty)
  );

  assign wready_o = (state_q == ST_DATA) && (!out_vld_q || wr_rdy_i);
  assign w_acc    = wready_o & wvalid_i;
  assign w_final  = (rem_q == 8'd0);
  assign sink_acc = out_vld_q & wr_rdy_i;
  assign incr     = ADDR_W'(1) << size_q;

  always_comb begin
    case (mode_q)
      BURST_FIXED: addr_nx = addr_q;
`ifdef AXI_WR_WRAP_EN
      BURST_WRAP:  addr_nx = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
`endif
      default:     addr_nx = addr_q + incr;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    aw_pop       = 1'b0;
    id_d         = id_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    size_d       = size_q;
    mode_d       = mode_q;
    region_d     = region_q;
    err_d        = err_q;
    supp_d       = supp_q;
    bvalid_d     = bvalid_q;
    out_vld_d    = out_vld_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    out_strb_d   = out_strb_q;
    out_region_d = out_region_q;
    out_last_d   = out_last_q;
`ifdef AXI_WR_WRAP_EN
    len_d        = len_q;
`endif
    case (state_q)
      ST_IDLE: if (!aw_empty) state_d = ST_LOAD;
      ST_LOAD: begin
        aw_pop   = 1'b1;
        id_d     = ent_id;
        addr_d   = ent_addr;
        rem_d    = ent_len;
        size_d   = ent_size;
        region_d = ent_region;
        err_d    = ent_err;
        supp_d   = (ent_size > SIZE_MAX);
`ifdef AXI_WR_WRAP_EN
        len_d    = ent_len;
`endif
        case (ent_burst)
          BURST_FIXED: mode_d = BURST_FIXED;
`ifdef AXI_WR_WRAP_EN
          BURST_WRAP:  mode_d = BURST_WRAP;
`endif
          default:     mode_d = BURST_INCR;
        endcase
        state_d = ST_DATA;
      end
      ST_DATA: if (w_acc) begin
        // The beat counter decides where the burst ends; WLAST only flags disagreement.
        addr_d = addr_nx;
        rem_d  = rem_q - 1'b1;
        if (w_final != wlast_i) err_d = 1'b1;
        if (w_final) begin
          state_d = ST_RESP;
          if (supp_q) bvalid_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (sink_acc && out_last_q) bvalid_d = 1'b1;
        if (bvalid_q && bready_i) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (sink_acc && wr_err_i) err_d = 1'b1;
    if (sink_acc) out_vld_d = 1'b0;
    if (w_acc && !supp_q) begin
      out_vld_d    = 1'b1;
      out_addr_d   = addr_q;
      out_data_d   = wdata_i;
      out_strb_d   = wstrb_i;
      out_region_d = region_q;
      out_last_d   = w_final;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      id_q         <= '0;
      addr_q       <= '0;
      rem_q        <= '0;
      size_q       <= '0;
      mode_q       <= BURST_INCR;
      region_q     <= '0;
      err_q        <= 1'b0;
      supp_q       <= 1'b0;
      bvalid_q     <= 1'b0;
      out_vld_q    <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      out_strb_q   <= '0;
      out_region_q <= '0;
      out_last_q   <= 1'b0;
`ifdef AXI_WR_WRAP_EN
      len_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      size_q       <= size_d;
      mode_q       <= mode_d;
      region_q     <= region_d;
      err_q        <= err_d;
      supp_q       <= supp_d;
      bvalid_q     <= bvalid_d;
      out_vld_q    <= out_vld_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      out_strb_q   <= out_strb_d;
      out_region_q <= out_region_d;
      out_last_q   <= out_last_d;
`ifdef AXI_WR_WRAP_EN
      len_q        <= len_d;
`endif
    end
  end

  assign bvalid_o    = bvalid_q;
  assign bid_o       = bvalid_q ? id_q : '0;
  assign bresp_o     = (bvalid_q && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign wr_vld_o    = out_vld_q;
  assign wr_addr_o   = out_addr_q;
  assign wr_data_o   = out_data_q;
  assign wr_strb_o   = out_strb_q;
  assign wr_region_o = out_region_q;
  assign wr_last_o   = out_vld_q & out_last_q;

endmodule

// File: tb/tb_axi_wr_burst_slv.sv
// Self-checking bench for axi_wr_burst_slv: expected sink beats and B responses are
// queued when a burst is issued and compared as the DUT produces them.
module tb_axi_wr_burst_slv;

  localparam int ID_W = 8, ADDR_W = 11, DATA_W = 32, AW_DEPTH = 4, STRB_W = 4;

  logic              clk, rst;
  logic [ID_W-1:0]   awid_i;
  logic [ADDR_W-1:0] awaddr_i;
  logic [7:0]        awlen_i;
  logic [2:0]        awsize_i;
  logic [1:0]        awburst_i;
  logic [3:0]        awregion_i;
  logic              awvalid_i, awready_o;
  logic [DATA_W-1:0] wdata_i;
  logic [STRB_W-1:0] wstrb_i;
  logic              wlast_i, wvalid_i, wready_o;
  logic [ID_W-1:0]   bid_o;
  logic [1:0]        bresp_o;
  logic              bvalid_o, bready_i;
  logic              wr_vld_o, wr_rdy_i;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;
  logic [STRB_W-1:0] wr_strb_o;
  logic [3:0]        wr_region_o;
  logic              wr_last_o, wr_err_i;

  axi_wr_burst_slv #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AW_DEPTH(AW_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
    .awburst_i(awburst_i), .awregion_i(awregion_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .wr_vld_o(wr_vld_o), .wr_rdy_i(wr_rdy_i), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .wr_strb_o(wr_strb_o), .wr_region_o(wr_region_o), .wr_last_o(wr_last_o), .wr_err_i(wr_err_i)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_tests, n_fail;
  logic [43:0] exp_q[$];    // {last, addr, data}
  logic [9:0]  exp_b_q[$];  // {id, resp}
  logic [43:0] exp_e;
  logic [9:0]  exp_b;
  bit          rnd_rdy, bp_arm, prev_stall;
  int          hold_cnt, bp_cnt;
  logic [31:0] prev_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] model_addr(input logic [10:0] start, input int beat,
                                             input logic [7:0] len, input logic [2:0] size,
                                             input int mode);
    int bytes, wb, base, off;
    bytes = 1 << size;
    if (mode == 0) return start;
    if (mode == 2) begin
      wb   = (int'(len) + 1) * bytes;
      base = (int'(start) / wb) * wb;
      off  = (int'(start) - base + beat * bytes) % wb;
      return 11'(base + off);
    end
    return 11'((int'(start) + beat * bytes) % 2048);
  endfunction

  function automatic logic [31:0] beat_data(input logic [31:0] seed, input int b);
    return seed + 32'(b) * 32'h0101_0101;
  endfunction

  // ---------------- sink / B-ready driver ----------------
  initial begin
    wr_rdy_i = 1'b1;
    bready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (hold_cnt > 0) begin
        wr_rdy_i = 1'b0;
        hold_cnt--;
      end else if (rnd_rdy) begin
        wr_rdy_i = ($urandom_range(0, 3) != 0);
        bready_i = ($urandom_range(0, 2) != 0);
      end else begin
        wr_rdy_i = 1'b1;
        bready_i = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wr_vld_o && !wr_rdy_i) begin
          chk("stall_wready", 64'(wready_o), 64'd0);
          if (prev_stall) chk("stall_data", 64'(wr_data_o), 64'(prev_data));
        end
        prev_stall = wr_vld_o && !wr_rdy_i;
        prev_data  = wr_data_o;
        if (wr_vld_o && wr_rdy_i) begin
          if (exp_q.size() == 0) begin
            chk("unexp_beat", 64'd1, 64'd0);
          end else begin
            exp_e = exp_q.pop_front();
            chk("wr_addr", 64'(wr_addr_o), 64'(exp_e[42:32]));
            chk("wr_data", 64'(wr_data_o), 64'(exp_e[31:0]));
            chk("wr_last", 64'(wr_last_o), 64'(exp_e[43]));
          end
          if (bp_arm) begin
            bp_cnt++;
            if (bp_cnt == 2) hold_cnt = 3;
          end
        end
        if (bvalid_o && bready_i) begin
          if (exp_b_q.size() == 0) begin
            chk("unexp_b", 64'd1, 64'd0);
          end else begin
            exp_b = exp_b_q.pop_front();
            chk("bid", 64'(bid_o), 64'(exp_b[9:2]));
            chk("bresp", 64'(bresp_o), 64'(exp_b[1:0]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks (called just after a rising edge) ----------------
  task automatic send_aw(input logic [7:0] id, input logic [10:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit hs;
    int budget;
    awid_i = id; awaddr_i = addr; awlen_i = len; awsize_i = size; awburst_i = burst;
    awregion_i = id[3:0]; awvalid_i = 1'b1;
    hs = 1'b0; budget = 0;
    while (!hs && budget < 500) begin
      @(negedge clk); hs = awready_o;
      @(posedge clk); #1;
      budget++;
    end
    awvalid_i = 1'b0;
    chk("aw_handshake", 64'(hs), 64'd1);
  endtask

  task automatic send_w_beat(input logic [31:0] data, input logic last);
    bit hs;
    int budget;
    wdata_i = data; wstrb_i = 4'hF; wlast_i = last; wvalid_i = 1'b1;
    hs = 1'b0; budget = 0;
    while (!hs && budget < 500) begin
      @(negedge clk); hs = wready_o;
      @(posedge clk); #1;
      budget++;
    end
    wvalid_i = 1'b0;
    if (!hs) chk("w_timeout", 64'(hs), 64'd1);
  endtask

  task automatic push_exp(input logic [7:0] id, input logic [10:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input int mode, input bit supp,
                          input logic [1:0] resp, input logic [31:0] seed);
    for (int b = 0; b <= int'(len); b++) begin
      if (!supp) exp_q.push_back({(b == int'(len)), model_addr(addr, b, len, size, mode), beat_data(seed, b)});
    end
    exp_b_q.push_back({id, resp});
  endtask

  task automatic w_burst(input logic [7:0] len, input logic [31:0] seed, input int early_idx);
    for (int b = 0; b <= int'(len); b++) begin
      send_w_beat(beat_data(seed, b), (early_idx >= 0) ? (b == early_idx) : (b == int'(len)));
    end
  endtask

  task automatic do_burst(input logic [7:0] id, input logic [10:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int mode,
                          input int early_idx, input bit supp, input logic [1:0] resp);
    logic [31:0] seed;
    seed = $urandom;
    push_exp(id, addr, len, size, mode, supp, resp, seed);
    send_aw(id, addr, len, size, burst);
    w_burst(len, seed, early_idx);
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || exp_b_q.size() != 0) && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    chk("drain", 64'(exp_q.size() + exp_b_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] seeds [5];
  logic [31:0] rs;

  initial begin
    n_tests = 0; n_fail = 0;
    rnd_rdy = 0; bp_arm = 0; hold_cnt = 0; bp_cnt = 0; prev_stall = 0; prev_data = '0;
    rst = 1'b1;
    awid_i = '0; awaddr_i = '0; awlen_i = '0; awsize_i = '0; awburst_i = '0; awregion_i = '0;
    awvalid_i = 1'b0; wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0; wr_err_i = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_awready", 64'(awready_o), 64'd0);
    chk("rst_wready", 64'(wready_o), 64'd0);
    chk("rst_bvalid", 64'(bvalid_o), 64'd0);
    chk("rst_wr_vld", 64'(wr_vld_o), 64'd0);
    chk("rst_wr_last", 64'(wr_last_o), 64'd0);
    chk("rst_bresp", 64'(bresp_o), 64'd0);
    chk("rst_bid", 64'(bid_o), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // INCR, size 2: 0x010/0x014/0x018/0x01C
    do_burst(8'hA1, 11'h010, 8'd3, 3'd2, 2'b01, 1, -1, 1'b0, 2'b00);
    wait_drain();
    // INCR wrapping past the top of the address space
    do_burst(8'h88, 11'h7F8, 8'd3, 3'd2, 2'b01, 1, -1, 1'b0, 2'b00);
    wait_drain();
    // FIXED keeps the start address
    do_burst(8'h22, 11'h0F0, 8'd2, 3'd2, 2'b00, 0, -1, 1'b0, 2'b00);
    wait_drain();

    // Outstanding AWs with W held off; one entry is taken by the engine, four sit in the queue
    for (int i = 0; i < 5; i++) begin
      seeds[i] = $urandom;
      push_exp(8'(8'h10 + i), 11'(11'h200 + i * 16), 8'd0, 3'd2, 1, 1'b0, 2'b00, seeds[i]);
      send_aw(8'(8'h10 + i), 11'(11'h200 + i * 16), 8'd0, 3'd2, 2'b01);
    end
    @(negedge clk);
    chk("aw_full", 64'(awready_o), 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) w_burst(8'd0, seeds[i], -1);
    wait_drain();

    // Sink backpressure for three cycles after the second beat
    bp_arm = 1'b1; bp_cnt = 0;
    do_burst(8'h33, 11'h080, 8'd5, 3'd2, 2'b01, 1, -1, 1'b0, 2'b00);
    wait_drain();
    bp_arm = 1'b0;

    // Error cases
    do_burst(8'h44, 11'h100, 8'd3, 3'd2, 2'b01, 1, 1, 1'b0, 2'b10);   // early WLAST
    wait_drain();
    do_burst(8'h55, 11'h000, 8'd1, 3'd3, 2'b01, 1, -1, 1'b1, 2'b10);  // size too wide
    wait_drain();
    do_burst(8'h66, 11'h040, 8'd1, 3'd2, 2'b11, 1, -1, 1'b0, 2'b10);  // reserved burst type
    wait_drain();
    wr_err_i = 1'b1;
    do_burst(8'h99, 11'h300, 8'd1, 3'd2, 2'b01, 1, -1, 1'b0, 2'b10);  // sink error
    wait_drain();
    wr_err_i = 1'b0;

`ifdef AXI_WR_WRAP_EN
    do_burst(8'hB2, 11'h038, 8'd3, 3'd2, 2'b10, 2, -1, 1'b0, 2'b00);
`else
    do_burst(8'hB2, 11'h038, 8'd3, 3'd2, 2'b10, 1, -1, 1'b0, 2'b10);
`endif
    wait_drain();

    // Random INCR/FIXED bursts with a random sink and B-ready
    rnd_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [2:0]  sz;
      logic [7:0]  ln;
      logic [10:0] ad;
      int          md;
      sz = 3'($urandom_range(0, 2));
      ln = 8'($urandom_range(0, 7));
      md = $urandom_range(0, 1);
      rs = $urandom;
      ad = 11'(rs) & ~11'((1 << sz) - 1);
      do_burst(8'(8'hC0 + i), ad, ln, sz, 2'(md), md, -1, 1'b0, 2'b00);
    end
    wait_drain();
    rnd_rdy = 1'b0;
    @(posedge clk); #1;

    // Reset during beat 2: beats 0 and 1 reach the sink, no response is produced
    rs = $urandom;
    exp_q.push_back({1'b0, 11'h100, beat_data(rs, 0)});
    exp_q.push_back({1'b0, 11'h104, beat_data(rs, 1)});
    send_aw(8'h77, 11'h100, 8'd3, 3'd2, 2'b01);
    send_w_beat(beat_data(rs, 0), 1'b0);
    send_w_beat(beat_data(rs, 1), 1'b0);
    wdata_i = beat_data(rs, 2); wlast_i = 1'b0; wvalid_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; wvalid_i = 1'b0;
    @(negedge clk);
    chk("mid_rst_awready", 64'(awready_o), 64'd0);
    chk("mid_rst_wready", 64'(wready_o), 64'd0);
    chk("mid_rst_bvalid", 64'(bvalid_o), 64'd0);
    chk("mid_rst_wr_vld", 64'(wr_vld_o), 64'd0);
    chk("mid_rst_wr_last", 64'(wr_last_o), 64'd0);
    chk("mid_rst_bresp", 64'(bresp_o), 64'd0);
    chk("mid_rst_bid", 64'(bid_o), 64'd0);
    chk("mid_rst_exp_left", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_awready", 64'(awready_o), 64'd1);
    @(posedge clk); #1;
    do_burst(8'h5A, 11'h020, 8'd3, 3'd2, 2'b01, 1, -1, 1'b0, 2'b00);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
